// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage in-order LoongArch pipeline.
// Holds the instruction handed over by exe and takes the data-SRAM read data
// that arrives one cycle after exe issued the address. It also selects the
// load byte/half/word lane and produces the value for writeback and for
// forwarding to ID.
//
// Handshake: a transfer from exe happens on a rising edge where
// exe_to_mem_valid and mem_allowin are both 1. A transfer to wb happens on a
// rising edge where mem_to_wb_valid and wb_allowin are both 1. mem never
// stalls by itself, so mem_allowin depends only on wb_allowin and occupancy.
module mem_stage #(
    parameter int EXE_TO_MEM_WD = 74,
    parameter int MEM_TO_WB_WD  = 70,
    parameter int MEM_TO_ID_WD  = 39
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic                     mem_allowin,
    input  logic                     exe_to_mem_valid,
    input  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
    input  logic                     wb_allowin,
    output logic                     mem_to_wb_valid,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus,
    input  logic [31:0]              data_sram_rdata
);

    logic                     mem_valid_q, mem_valid_d;
    logic [EXE_TO_MEM_WD-1:0] mem_data_q, mem_data_d;
    logic [31:0]              rdata_hold_q, rdata_hold_d;
    logic                     rdata_held_q, rdata_held_d;

    logic        mem_ready_go;
    logic        reg_w;
    logic [4:0]  reg_w_addr;
    logic        res_from_mem;
    logic [31:0] result;
    logic [1:0]  mem_ins_rec;
    logic        load_sign;
    logic [31:0] pc;
    logic [1:0]  addr_lo;
    logic [31:0] rdata;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] final_val;

    // Field unpacking of the latched exe-to-mem payload, MSB first.
    assign reg_w        = mem_data_q[73];
    assign reg_w_addr   = mem_data_q[72:68];
    assign res_from_mem = mem_data_q[67];
    assign result       = mem_data_q[66:35];
    assign mem_ins_rec  = mem_data_q[34:33];
    assign load_sign    = mem_data_q[32];
    assign pc           = mem_data_q[31:0];
    assign addr_lo      = result[1:0];

    assign mem_ready_go    = 1'b1;
    assign mem_allowin     = ~mem_valid_q | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid_q & mem_ready_go;

    // Next-state for occupancy, payload and the stalled-read-data capture.
    // A stalled load freezes the SRAM data it saw on its first stalled cycle,
    // since exe may re-issue and change the SRAM output meanwhile.
    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_data_d   = mem_data_q;
        rdata_hold_d = rdata_hold_q;
        rdata_held_d = rdata_held_q;
        if (mem_allowin) begin
            mem_valid_d  = exe_to_mem_valid;
            rdata_held_d = 1'b0;
            if (exe_to_mem_valid) begin
                mem_data_d = exe_to_mem_bus;
            end
        end else if (mem_valid_q && res_from_mem && !rdata_held_q) begin
            rdata_hold_d = data_sram_rdata;
            rdata_held_d = 1'b1;
        end
    end

    // Control state: cleared by reset, otherwise follows next-state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            rdata_held_q <= 1'b0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            rdata_held_q <= rdata_held_d;
        end
    end

    // Datapath registers: no reset, contents only matter while valid/held.
    always_ff @(posedge clk) begin
        mem_data_q   <= mem_data_d;
        rdata_hold_q <= rdata_hold_d;
    end

    assign rdata = rdata_held_q ? rdata_hold_q : data_sram_rdata;

    // Load lane selection and sign/zero extension.
    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = 32'h0;
        case (mem_ins_rec)
            2'b01: load_data = {{24{load_sign & byte_lane[7]}}, byte_lane};
            2'b10: load_data = {{16{load_sign & half_lane[15]}}, half_lane};
            2'b11: load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

    assign final_val = res_from_mem ? load_data : result;

    assign mem_to_wb_bus = {reg_w, reg_w_addr, final_val, pc};
    assign mem_to_id_bus = {mem_valid_q, reg_w, reg_w_addr, final_val};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed load/stall/reset scenarios plus randomized traffic
// against a behavioural model of the memory stage.
module tb_mem_stage;
  localparam int EW = 74;
  localparam int WW = 70;
  localparam int IW = 39;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          mem_allowin;
  logic          exe_to_mem_valid;
  logic [EW-1:0] exe_to_mem_bus;
  logic          wb_allowin;
  logic          mem_to_wb_valid;
  logic [WW-1:0] mem_to_wb_bus;
  logic [IW-1:0] mem_to_id_bus;
  logic [31:0]   data_sram_rdata;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_id_bus    (mem_to_id_bus),
    .data_sram_rdata  (data_sram_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---- reference model state: the instruction occupying mem ----
  logic        m_valid = 1'b0;
  logic        m_first = 1'b0;
  logic        m_regw;
  logic [4:0]  m_addr;
  logic        m_rfm;
  logic [31:0] m_result;
  logic [1:0]  m_ins;
  logic        m_sign;
  logic [31:0] m_pc;
  logic [31:0] m_lr;

  task automatic check_eq(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [EW-1:0] mk_bus(input logic regw, input logic [4:0] addr,
                                           input logic rfm, input logic [31:0] res,
                                           input logic [1:0] ins, input logic sgn,
                                           input logic [31:0] pc);
    return {regw, addr, rfm, res, ins, sgn, pc};
  endfunction

  // Load value from the architectural rules: shift the addressed lane down,
  // mask it, then extend.
  function automatic logic [31:0] model_load(input logic [1:0] ins, input logic [1:0] a,
                                             input logic sgn, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    v = 32'h0;
    if (ins == 2'b01) begin
      sh = 8 * int'(a);
      v = (rd >> sh) & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (ins == 2'b10) begin
      sh = a[1] ? 16 : 0;
      v = (rd >> sh) & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else if (ins == 2'b11) begin
      v = rd;
    end
    return v;
  endfunction

  // ---- driver: apply one cycle's inputs, then compare against the model ----
  task automatic drive(input logic v, input logic [EW-1:0] bus, input logic wb, input logic [31:0] rd);
    logic [31:0] fin;
    exe_to_mem_valid = v;
    exe_to_mem_bus   = bus;
    wb_allowin       = wb;
    data_sram_rdata  = rd;
    #1;
    if (m_valid && m_first) m_lr = data_sram_rdata;
    check_eq("allowin", 70'(mem_allowin), 70'(!m_valid || wb));
    check_eq("wb_valid", 70'(mem_to_wb_valid), 70'(m_valid));
    check_eq("id_valid", 70'(mem_to_id_bus[38]), 70'(m_valid));
    if (m_valid) begin
      fin = m_rfm ? model_load(m_ins, m_result[1:0], m_sign, m_lr) : m_result;
      check_eq("wb_bus", 70'(mem_to_wb_bus), {m_regw, m_addr, fin, m_pc});
      check_eq("id_bus", 70'(mem_to_id_bus), 70'({1'b1, m_regw, m_addr, fin}));
    end
  endtask

  // Clock edge: advance the model with the inputs that were applied.
  task automatic tick();
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0;
    end else if (!m_valid || wb_allowin) begin
      m_valid = exe_to_mem_valid;
      if (exe_to_mem_valid) begin
        {m_regw, m_addr, m_rfm, m_result, m_ins, m_sign, m_pc} = exe_to_mem_bus;
        m_first = 1'b1;
      end
    end else begin
      m_first = 1'b0;
    end
    #1;
  endtask

  logic [EW-1:0] idle_bus;

  initial begin
    idle_bus = '0;
    resetn = 1'b0;
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus = '0;
    wb_allowin = 1'b1;
    data_sram_rdata = 32'h0;
    tick();
    tick();
    resetn = 1'b1;

    // reset state
    drive(1'b0, idle_bus, 1'b1, 32'h0);
    check_eq("rst_allowin", 70'(mem_allowin), 70'(1));
    check_eq("rst_idvalid", 70'(mem_to_id_bus[38]), 70'(0));
    tick();

    // ld.w with one-cycle latency
    drive(1'b1, mk_bus(1'b1, 5'd3, 1'b1, 32'h1C00_0010, 2'b11, 1'b0, 32'h1C00_0000), 1'b1, 32'hDEAD_BEEF);
    check_eq("ldw_early", 70'(mem_to_wb_valid), 70'(0));
    tick();
    drive(1'b0, idle_bus, 1'b1, 32'h8765_4321);
    check_eq("ldw_valid", 70'(mem_to_wb_valid), 70'(1));
    check_eq("ldw_final", 70'(mem_to_wb_bus[63:32]), 70'(32'h8765_4321));
    tick();

    // ld.b / ld.bu at byte 3
    drive(1'b1, mk_bus(1'b1, 5'd6, 1'b1, 32'h0000_1003, 2'b01, 1'b1, 32'h1C00_0004), 1'b1, 32'h0);
    tick();
    drive(1'b1, mk_bus(1'b1, 5'd7, 1'b1, 32'h0000_1003, 2'b01, 1'b0, 32'h1C00_0008), 1'b1, 32'h80FF_1234);
    check_eq("ldb_final", 70'(mem_to_wb_bus[63:32]), 70'(32'hFFFF_FF80));
    tick();
    drive(1'b1, mk_bus(1'b1, 5'd8, 1'b1, 32'h0000_2002, 2'b10, 1'b1, 32'h1C00_000C), 1'b1, 32'h80FF_1234);
    check_eq("ldbu_final", 70'(mem_to_wb_bus[63:32]), 70'(32'h0000_0080));
    tick();
    // ld.h at half 1, then ld.hu at half 0
    drive(1'b1, mk_bus(1'b1, 5'd9, 1'b1, 32'h0000_2000, 2'b10, 1'b0, 32'h1C00_0010), 1'b1, 32'hF00D_1234);
    check_eq("ldh_final", 70'(mem_to_wb_bus[63:32]), 70'(32'hFFFF_F00D));
    tick();
    drive(1'b0, idle_bus, 1'b1, 32'hF00D_1234);
    check_eq("ldhu_final", 70'(mem_to_wb_bus[63:32]), 70'(32'h0000_1234));
    tick();

    // stall: load held for 3 cycles while SRAM data changes and exe re-issues
    drive(1'b1, mk_bus(1'b1, 5'd10, 1'b1, 32'h0000_3000, 2'b11, 1'b0, 32'h1C00_0020), 1'b1, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk_bus(1'b1, 5'd11, 1'b0, 32'h0000_0077, 2'b00, 1'b0, 32'h1C00_0024), 1'b0,
            (i == 0) ? 32'h1111_1111 : 32'h2222_2222);
      check_eq("stall_final", 70'(mem_to_wb_bus[63:32]), 70'(32'h1111_1111));
      check_eq("stall_allowin", 70'(mem_allowin), 70'(0));
      tick();
    end
    drive(1'b1, mk_bus(1'b1, 5'd11, 1'b0, 32'h0000_0077, 2'b00, 1'b0, 32'h1C00_0024), 1'b1, 32'h2222_2222);
    check_eq("release_final", 70'(mem_to_wb_bus[63:32]), 70'(32'h1111_1111));
    tick();

    // ALU op forwarding, then bubble
    drive(1'b1, mk_bus(1'b1, 5'd4, 1'b0, 32'h0000_0005, 2'b00, 1'b0, 32'h1C00_0030), 1'b1, 32'h0);
    tick();
    drive(1'b0, idle_bus, 1'b1, 32'hCAFE_0000);
    check_eq("alu_idbus", 70'(mem_to_id_bus), 70'({1'b1, 1'b1, 5'd4, 32'd5}));
    tick();
    drive(1'b0, idle_bus, 1'b1, 32'h0);
    check_eq("bubble_idvalid", 70'(mem_to_id_bus[38]), 70'(0));
    tick();

    // reset while a stalled load sits in mem
    drive(1'b1, mk_bus(1'b1, 5'd12, 1'b1, 32'h0000_4000, 2'b11, 1'b0, 32'h1C00_0040), 1'b1, 32'h0);
    tick();
    resetn = 1'b0;
    drive(1'b0, idle_bus, 1'b0, 32'h3333_3333);
    tick();
    resetn = 1'b1;
    drive(1'b0, idle_bus, 1'b0, 32'h0);
    check_eq("mrst_valid", 70'(mem_to_wb_valid), 70'(0));
    check_eq("mrst_allowin", 70'(mem_allowin), 70'(1));
    check_eq("mrst_idvalid", 70'(mem_to_id_bus[38]), 70'(0));
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [EW-1:0] rb;
      rb = mk_bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      resetn = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 3) != 0), rb, 1'($urandom_range(0, 2) != 0), $urandom);
      tick();
    end
    resetn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
